// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter merging NUM_SRC AXI-Stream sources onto one stream.
// Optional packet counter output pkt_cnt is enabled by defining AXIS_ARB_PKT_CNT_EN.
module axis_packet_arbiter #(
  parameter int DATA_W  = 64,
  parameter int NUM_SRC = 4
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [NUM_SRC-1:0]          s_axis_tvalid,
  output logic [NUM_SRC-1:0]          s_axis_tready,
  input  logic [NUM_SRC*DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_SRC-1:0]          s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic                        m_axis_tlast,
  output logic                        grant_valid,
  output logic [$clog2(NUM_SRC)-1:0]  grant_idx
`ifdef AXIS_ARB_PKT_CNT_EN
  ,
  output logic [31:0]                 pkt_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_SRC);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] w_grant_idx_next;
  logic [IDX_W-1:0] r_last_grant;
  logic [IDX_W-1:0] w_last_grant_next;
  logic             r_grant_valid;
  logic             w_grant_valid_next;
  logic [IDX_W-1:0] w_pick;
  logic             w_found;
  logic             w_active;
  logic             w_done;
  int               w_cand;

  // Round-robin search starting just after the previously served source.
  always_comb begin
    w_pick  = r_last_grant;
    w_found = 1'b0;
    w_cand  = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_cand = int'(r_last_grant) + k;
      if (w_cand >= NUM_SRC) w_cand = w_cand - NUM_SRC;
      if (!w_found && s_axis_tvalid[w_cand[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_grant_idx_next   = r_grant_idx;
    w_last_grant_next  = r_last_grant;
    w_grant_valid_next = r_grant_valid;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_next       = GRANT;
          w_grant_idx_next   = w_pick;
          w_grant_valid_next = 1'b1;
        end
      end
      GRANT: begin
        if (w_done) begin
          w_state_next       = IDLE;
          w_last_grant_next  = r_grant_idx;
          w_grant_valid_next = 1'b0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state       <= IDLE;
      r_grant_idx   <= '0;
      r_last_grant  <= IDX_W'(NUM_SRC - 1);
      r_grant_valid <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_grant_idx   <= w_grant_idx_next;
      r_last_grant  <= w_last_grant_next;
      r_grant_valid <= w_grant_valid_next;
    end
  end

  // Gating with areset keeps the stream quiet during the reset cycle itself.
  assign w_active      = (r_state == GRANT) && !areset;
  assign m_axis_tvalid = w_active && s_axis_tvalid[r_grant_idx];
  assign m_axis_tlast  = w_active && s_axis_tlast[r_grant_idx];
  assign m_axis_tdata  = w_active ? s_axis_tdata[int'(r_grant_idx)*DATA_W +: DATA_W] : '0;
  assign w_done        = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign grant_valid   = r_grant_valid;
  assign grant_idx     = r_grant_idx;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
      assign s_axis_tready[gi] = w_active && (r_grant_idx == IDX_W'(gi)) && m_axis_tready;
    end
  endgenerate

`ifdef AXIS_ARB_PKT_CNT_EN
  logic [31:0] r_pkt_cnt;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_pkt_cnt <= '0;
    end else if (w_done) begin
      r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end
  end

  assign pkt_cnt = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Scoreboard bench for axis_packet_arbiter; pkt_cnt checks run when AXIS_ARB_PKT_CNT_EN is defined.
module tb_axis_packet_arbiter;

  localparam int DW = 64;
  localparam int NS = 4;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [1:0]  src;
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic               aclk = 1'b0;
  logic               areset;
  logic [NS-1:0]      s_axis_tvalid;
  logic [NS-1:0]      s_axis_tready;
  logic [NS*DW-1:0]   s_axis_tdata;
  logic [NS-1:0]      s_axis_tlast;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic [DW-1:0]      m_axis_tdata;
  logic               m_axis_tlast;
  logic               grant_valid;
  logic [1:0]         grant_idx;
`ifdef AXIS_ARB_PKT_CNT_EN
  logic [31:0]        pkt_cnt;
`endif

  always #5 aclk = ~aclk;

  axis_packet_arbiter #(.DATA_W(DW), .NUM_SRC(NS)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx)
`ifdef AXIS_ARB_PKT_CNT_EN
    ,
    .pkt_cnt       (pkt_cnt)
`endif
  );

  beat_t       src_q [NS][$];
  exp_t        exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          seq      = 0;
  logic        flag_last, flag_gap, prev_stall;
  logic [63:0] prev_data;

  task automatic check_equal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic pending();
    logic p = 1'b0;
    for (int s = 0; s < NS; s++) if (src_q[s].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drive_srcs();
    for (int s = 0; s < NS; s++) begin
      if (src_q[s].size() > 0) begin
        s_axis_tvalid[s]          = 1'b1;
        s_axis_tdata[s*DW +: DW]  = src_q[s][0].data;
        s_axis_tlast[s]           = src_q[s][0].last;
      end else begin
        s_axis_tvalid[s]          = 1'b0;
        s_axis_tdata[s*DW +: DW]  = '0;
        s_axis_tlast[s]           = 1'b0;
      end
    end
  endtask

  task automatic push_pkt(input int src, input int nbeats);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < nbeats; i++) begin
      b.data = {16'hA5A5, 8'(src), 8'(i), 32'(seq)};
      b.last = (i == nbeats - 1);
      seq++;
      src_q[src].push_back(b);
      e.src  = 2'(src);
      e.data = b.data;
      e.last = b.last;
      exp_q.push_back(e);
    end
  endtask

  // Output monitor: scoreboard compare, stall stability and inter-packet gap.
  task automatic monitor();
    exp_t e;
    if (areset) begin
      flag_last  = 1'b0;
      flag_gap   = 1'b0;
      prev_stall = 1'b0;
      return;
    end
    if (flag_last) begin
      check_equal("gap_grant_valid", grant_valid, 1'b0);
      check_equal("gap_m_tvalid", m_axis_tvalid, 1'b0);
      flag_gap  = pending();
      flag_last = 1'b0;
    end else if (flag_gap) begin
      check_equal("regrant_after_one_idle", grant_valid, 1'b1);
      flag_gap = 1'b0;
    end
    if (prev_stall && m_axis_tvalid) check_equal("stall_hold_data", m_axis_tdata, prev_data);
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check_equal("unexpected_beat", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        $display("beat src=%0d data=%h last=%0b", grant_idx, m_axis_tdata, m_axis_tlast);
        check_equal("beat_src", grant_idx, e.src);
        check_equal("beat_data", m_axis_tdata, e.data);
        check_equal("beat_last", m_axis_tlast, e.last);
        flag_last = m_axis_tlast;
      end
    end
  endtask

  // One clock: observe just after the negedge, advance sources just after the posedge.
  task automatic tick();
    logic [NS-1:0] hs;
    #1;
    monitor();
    hs = s_axis_tvalid & s_axis_tready;
    @(posedge aclk);
    #1;
    for (int s = 0; s < NS; s++) if (hs[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
    drive_srcs();
    @(negedge aclk);
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check_equal("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    tick();
    check_equal("rst_grant_valid", grant_valid, 1'b0);
    check_equal("rst_grant_idx", grant_idx, 2'd0);
    check_equal("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check_equal("rst_s_tready", s_axis_tready, 4'b0000);
`ifdef AXIS_ARB_PKT_CNT_EN
    check_equal("rst_pkt_cnt", pkt_cnt, 32'd0);
`endif
    areset = 1'b0;
  endtask

  initial begin
    flag_last     = 1'b0;
    flag_gap      = 1'b0;
    prev_stall    = 1'b0;
    prev_data     = '0;
    areset        = 1'b1;
    m_axis_tready = 1'b0;
    drive_srcs();
    @(negedge aclk);
    do_reset();

    // Source 2 alone, 3 beats, ready held high.
    m_axis_tready = 1'b1;
    push_pkt(2, 3);
    drive_srcs();
    check_equal("s1_pre_grant_valid", grant_valid, 1'b0);
    tick();
    check_equal("s1_grant_valid", grant_valid, 1'b1);
    check_equal("s1_grant_idx", grant_idx, 2'd2);
    check_equal("s1_m_tvalid", m_axis_tvalid, 1'b1);
    run_until_empty(20);
    check_equal("s1_released", grant_valid, 1'b0);

    // All four sources busy with 2-beat packets: order 0,1,2,3,0.
    do_reset();
    push_pkt(0, 2);
    push_pkt(1, 2);
    push_pkt(2, 2);
    push_pkt(3, 2);
    push_pkt(0, 2);
    drive_srcs();
    run_until_empty(60);

    // Source 1 mid-packet while 0 and 3 raise requests: no switch, then 3, then 0.
    push_pkt(1, 4);
    drive_srcs();
    tick();
    tick();
    push_pkt(3, 1);
    push_pkt(0, 2);
    drive_srcs();
    tick();
    check_equal("s3_no_switch", grant_idx, 2'd1);
    run_until_empty(40);

    // Ready toggling during a 4-beat packet from source 2.
    push_pkt(2, 4);
    drive_srcs();
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      m_axis_tready = (k % 2) == 0;
      tick();
    end
    check_equal("s4_drain", 64'(exp_q.size()), 64'd0);
    m_axis_tready = 1'b1;
    tick();

    // Reset during beat 2 of a source 3 packet, then sources 0 and 3 compete.
    push_pkt(3, 4);
    drive_srcs();
    tick();
    tick();
    check_equal("s5_beat2_presented", m_axis_tvalid, 1'b1);
    areset = 1'b1;
    tick();
    check_equal("s5_rst_m_tvalid", m_axis_tvalid, 1'b0);
    check_equal("s5_rst_s_tready", s_axis_tready, 4'b0000);
    check_equal("s5_rst_grant_valid", grant_valid, 1'b0);
    areset = 1'b0;
    src_q[3].delete();
    exp_q.delete();
    push_pkt(0, 1);
    push_pkt(3, 1);
    drive_srcs();
    tick();
    check_equal("s5_first_after_rst", grant_idx, 2'd0);
    run_until_empty(20);

`ifdef AXIS_ARB_PKT_CNT_EN
    // Counter wrap: preset near the top, then two packets.
    tick();
    force dut.r_pkt_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_pkt_cnt;
    push_pkt(1, 1);
    drive_srcs();
    run_until_empty(20);
    check_equal("pkt_cnt_max", pkt_cnt, 32'hFFFF_FFFF);
    push_pkt(1, 2);
    drive_srcs();
    run_until_empty(20);
    check_equal("pkt_cnt_wrap", pkt_cnt, 32'd0);
`endif

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning the per-source and output tdata width in bits.
REQ-002 The block SHALL have parameter NUM_SRC, default 4 (legal range 2..16), meaning the number of requesting AXI-Stream sources.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port aclk, input, 1 bit: the clock; all logic uses its rising edge.
REQ-005 The block SHALL have port areset, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port s_axis_tvalid, input, NUM_SRC bits: per-source valid.
REQ-007 The block SHALL have port s_axis_tready, output, NUM_SRC bits: per-source ready.
REQ-008 The block SHALL have port s_axis_tdata, input, NUM_SRC*DATA_W bits: source i data in slice [i*DATA_W +: DATA_W].
REQ-009 The block SHALL have port s_axis_tlast, input, NUM_SRC bits: per-source end-of-packet.
REQ-010 The block SHALL have ports m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tdata (output, DATA_W) and m_axis_tlast (output, 1): the shared stream toward the downstream width converter.
REQ-011 The block SHALL have port grant_valid, output, 1 bit: high while a packet grant is held.
REQ-012 The block SHALL have port grant_idx, output, clog2(NUM_SRC) bits: index of the granted source.

Function
REQ-013 The FSM SHALL have two states: IDLE and GRANT.
REQ-014 In IDLE with any s_axis_tvalid set, the block SHALL choose the first valid source searching round-robin from last_grant+1 (modulo NUM_SRC) and register it in grant_idx.
REQ-015 On that same edge the block SHALL set grant_valid=1 and enter GRANT, giving a fixed 1-cycle arbitration latency.
REQ-016 In IDLE with no source valid, the block SHALL stay in IDLE with all outputs inactive.
REQ-017 In GRANT, the block SHALL drive m_axis_tvalid, m_axis_tdata and m_axis_tlast combinationally from source grant_idx.
REQ-018 In GRANT, the block SHALL drive s_axis_tready[grant_idx] = m_axis_tready and hold all other s_axis_tready bits at 0.
REQ-019 In IDLE, all s_axis_tready bits and m_axis_tvalid SHALL be 0.
REQ-020 A grant SHALL be held until a handshake (m_axis_tvalid & m_axis_tready) with m_axis_tlast=1; on that edge the block SHALL set last_grant=grant_idx, clear grant_valid and return to IDLE.
REQ-021 There SHALL be no re-arbitration mid-packet: a granted source that drops tvalid yields m_axis_tvalid=0 while the grant persists.
REQ-022 Requests arriving during GRANT SHALL be considered only at the next IDLE.
REQ-023 The block SHALL insert exactly one idle cycle between consecutive packets, including back-to-back packets from the same source.
REQ-024 A tlast beat with m_axis_tready=0 SHALL be held stable until accepted.
REQ-025 Single-beat packets (tvalid and tlast in the first GRANT cycle) SHALL complete in one GRANT cycle.
REQ-026 With all NUM_SRC sources continuously valid, the grant order SHALL be 0,1,...,NUM_SRC-1,0,...
REQ-027 Data SHALL pass through the block unmodified; the block SHALL NOT buffer, reorder or drop beats.

Reset
REQ-028 While areset=1 at an edge, the block SHALL set state=IDLE, grant_valid=0, grant_idx=0 and last_grant=NUM_SRC-1, so source 0 has first priority.
REQ-029 During and after reset, m_axis_tvalid and all s_axis_tready bits SHALL be 0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration restarts from source 0 with no partial-packet recovery.

Configuration
REQ-031 With macro AXIS_ARB_PKT_CNT_EN defined, the block SHALL add output pkt_cnt (32 bits, reset 0) that increments by 1 on each accepted tlast beat and wraps from 0xFFFFFFFF to 0.
REQ-032 Without AXIS_ARB_PKT_CNT_EN, the pkt_cnt port and its counter SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-033 Bench scenario: reset, then source 2 alone sends a 3-beat packet with m_axis_tready=1 -> grant_idx=2 one cycle later, three beats out, then grant_valid=0.
REQ-034 Bench scenario: all 4 sources continuously valid with 2-beat packets -> packet order 0,1,2,3,0, with one idle cycle between packets.
REQ-035 Bench scenario: source 1 mid-packet while source 0 raises tvalid -> no switch until source 1's tlast; next grant goes to source 2 if valid, else 3, else 0.
REQ-036 Bench scenario: m_axis_tready toggling 1010 during a 4-beat packet -> all 4 beats delivered in order with data held stable while stalled.
REQ-037 Bench scenario: areset pulsed during beat 2 of a source 3 packet -> outputs are 0 next cycle; with sources 0 and 3 both then valid, source 0 is granted.
REQ-038 Bench scenario (AXIS_ARB_PKT_CNT_EN defined): pkt_cnt forced to 0xFFFFFFFE, then two packets sent -> pkt_cnt reads 0xFFFFFFFF, then 0.
